// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Generic inter-stage pipeline register. Carries an opaque DATA_W-bit payload
// between two pipeline stages using a valid/ready handshake. A stall is
// expressed as deasserted downstream ready. Flush turns every held entry into
// a bubble. Empty slots always hold BUBBLE_VAL, so o_data shows the nop
// bubble whenever o_valid is low.
//
// SKID = 0 : one main register M; o_ready is combinational (!M.valid || i_ready).
// SKID = 1 : main register M plus skid register S; o_ready depends only on
//            registered state (!S.valid), which cuts the ready path between
//            stages while keeping full throughput.
//
// Parameters
//   DATA_W      payload width in bits
//   BUBBLE_VAL  payload value held by an empty slot
//   SKID        0 = single register, 1 = main + skid register
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_reset      synchronous reset, active-high (priority over flush)
//   i_flush      kill all held and incoming entries this cycle
//   i_valid      upstream payload valid
//   o_ready      block accepts the upstream payload this cycle
//   i_data       upstream payload
//   o_valid      downstream payload valid
//   i_ready      downstream accepts the payload this cycle
//   o_data       downstream payload
//   o_occupancy  number of held entries (0..2)
//   o_stall_cnt  saturating count of cycles with o_valid && !i_ready
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int unsigned       DATA_W     = 192,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter bit                SKID       = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy,
  output logic [31:0]       o_stall_cnt
);

  // Main slot: always the entry presented downstream.
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  // Skid slot valid; stays 0 when SKID = 0.
  logic              s_valid;

  // Handshake events for this cycle.
  logic push;
  logic pop;

  assign push = i_valid && o_ready;
  assign pop  = m_valid && i_ready;

  assign o_valid     = m_valid;
  assign o_data      = m_data;
  assign o_occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  generate
    if (SKID) begin : g_skid
      logic              s_valid_q;
      logic [DATA_W-1:0] s_data;

      logic              m_valid_nxt;
      logic [DATA_W-1:0] m_data_nxt;
      logic              s_valid_nxt;
      logic [DATA_W-1:0] s_data_nxt;

      // Ready comes from registered state only; flush masks it so no entry
      // can slip in while the stage is being killed.
      assign o_ready = !i_flush && !s_valid_q;
      assign s_valid = s_valid_q;

      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch instead of a mux.
      always_comb begin
        m_valid_nxt = m_valid;
        m_data_nxt  = m_data;
        s_valid_nxt = s_valid_q;
        s_data_nxt  = s_data;

        if (i_flush) begin
          m_valid_nxt = 1'b0;
          m_data_nxt  = BUBBLE_VAL;
          s_valid_nxt = 1'b0;
          s_data_nxt  = BUBBLE_VAL;
        end else if (s_valid_q) begin
          // S full means o_ready is low, so only a pop can happen: the
          // older entry in S advances into M and S empties.
          if (pop) begin
            m_valid_nxt = 1'b1;
            m_data_nxt  = s_data;
            s_valid_nxt = 1'b0;
            s_data_nxt  = BUBBLE_VAL;
          end
        end else if (push && m_valid && !pop) begin
          // M is held downstream; park the new entry behind it.
          s_valid_nxt = 1'b1;
          s_data_nxt  = i_data;
        end else if (push) begin
          // M empty, or M leaving this cycle: the new entry goes straight to M.
          m_valid_nxt = 1'b1;
          m_data_nxt  = i_data;
        end else if (pop) begin
          m_valid_nxt = 1'b0;
          m_data_nxt  = BUBBLE_VAL;
        end
      end

      // NOTE: the data slots are reset too, not just the valid bits, because
      // an empty slot must read as BUBBLE_VAL on o_data straight out of reset.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          m_valid   <= 1'b0;
          m_data    <= BUBBLE_VAL;
          s_valid_q <= 1'b0;
          s_data    <= BUBBLE_VAL;
        end else begin
          m_valid   <= m_valid_nxt;
          m_data    <= m_data_nxt;
          s_valid_q <= s_valid_nxt;
          s_data    <= s_data_nxt;
        end
      end
    end else begin : g_single
      // Combinational ready: room exists if M is empty or leaving this cycle.
      assign o_ready = !i_flush && (!m_valid || i_ready);
      assign s_valid = 1'b0;

      always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
          m_valid <= 1'b0;
          m_data  <= BUBBLE_VAL;
        end else if (push) begin
          m_valid <= 1'b1;
          m_data  <= i_data;
        end else if (pop) begin
          m_valid <= 1'b0;
          m_data  <= BUBBLE_VAL;
        end
      end
    end
  endgenerate

  // Stall counter: counts cycles the stage holds a valid entry that the
  // downstream stage refuses. Saturates rather than wrapping; only reset
  // clears it, so a flush does not hide stalls from the profile.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_cnt <= 32'd0;
    end else if (m_valid && !i_ready && (o_stall_cnt != 32'hFFFF_FFFF)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Directed bench for pipe_stage_buf. Two instances share clock and reset:
// u_skid (SKID = 1) and u_single (SKID = 0), both 32-bit payload with a
// non-zero bubble value so that bubble loading is visible on o_data.
// Outputs are sampled 1 time unit after the rising edge; inputs change at
// the same point, so combinational o_ready is sampled after a further #1.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam int unsigned DW  = 32;
  localparam logic [DW-1:0] BUB = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;

  // SKID = 1 instance signals
  logic          sk_flush, sk_in_valid, sk_in_ready, sk_out_valid, sk_out_ready;
  logic [DW-1:0] sk_in_data, sk_out_data;
  logic [1:0]    sk_occ;
  logic [31:0]   sk_stall;

  // SKID = 0 instance signals
  logic          sg_flush, sg_in_valid, sg_in_ready, sg_out_valid, sg_out_ready;
  logic [DW-1:0] sg_in_data, sg_out_data;
  logic [1:0]    sg_occ;
  logic [31:0]   sg_stall;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID(1'b1)) u_skid (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_flush     (sk_flush),
    .i_valid     (sk_in_valid),
    .o_ready     (sk_in_ready),
    .i_data      (sk_in_data),
    .o_valid     (sk_out_valid),
    .i_ready     (sk_out_ready),
    .o_data      (sk_out_data),
    .o_occupancy (sk_occ),
    .o_stall_cnt (sk_stall)
  );

  pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID(1'b0)) u_single (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_flush     (sg_flush),
    .i_valid     (sg_in_valid),
    .o_ready     (sg_in_ready),
    .i_data      (sg_in_data),
    .o_valid     (sg_out_valid),
    .i_ready     (sg_out_ready),
    .o_data      (sg_out_data),
    .o_occupancy (sg_occ),
    .o_stall_cnt (sg_stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sk(input string tag, input logic v, input logic [DW-1:0] d, input logic [1:0] occ);
    check({tag, ".sk_valid"}, 64'(sk_out_valid), 64'(v));
    check({tag, ".sk_data"},  64'(sk_out_data),  64'(d));
    check({tag, ".sk_occ"},   64'(sk_occ),       64'(occ));
  endtask

  task automatic chk_sg(input string tag, input logic v, input logic [DW-1:0] d, input logic [1:0] occ);
    check({tag, ".sg_valid"}, 64'(sg_out_valid), 64'(v));
    check({tag, ".sg_data"},  64'(sg_out_data),  64'(d));
    check({tag, ".sg_occ"},   64'(sg_occ),       64'(occ));
  endtask

  initial begin
    // ---------------- reset with garbage on the inputs ----------------
    rst = 1'b1;
    sk_flush = 1'b0; sk_in_valid = 1'b1; sk_in_data = 32'hDEAD; sk_out_ready = 1'b0;
    sg_flush = 1'b0; sg_in_valid = 1'b1; sg_in_data = 32'hDEAD; sg_out_ready = 1'b0;
    tick();
    tick();
    chk_sk("reset", 1'b0, BUB, 2'd0);
    chk_sg("reset", 1'b0, BUB, 2'd0);
    check("reset.sk_stall", 64'(sk_stall), 64'd0);
    check("reset.sg_stall", 64'(sg_stall), 64'd0);
    rst = 1'b0;
    sk_in_valid = 1'b0;
    sg_in_valid = 1'b0;
    #1;
    check("reset.sk_ready", 64'(sk_in_ready), 64'd1);
    check("reset.sg_ready", 64'(sg_in_ready), 64'd1);

    // ---------------- SKID=1 streaming 1..4 ----------------
    sk_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sk_in_valid = 1'b1;
      sk_in_data  = 32'(i);
      #1;
      check($sformatf("stream%0d.ready", i), 64'(sk_in_ready), 64'd1);
      tick();
      chk_sk($sformatf("stream%0d", i), 1'b1, 32'(i), 2'd1);
    end
    sk_in_valid = 1'b0;
    tick();
    chk_sk("stream_drain", 1'b0, BUB, 2'd0);

    // ---------------- SKID=1 backpressure ----------------
    sk_out_ready = 1'b0;
    sk_in_valid  = 1'b1;
    sk_in_data   = 32'h0000_000A;
    tick();
    chk_sk("bp_a", 1'b1, 32'h0000_000A, 2'd1);
    check("bp_a.ready", 64'(sk_in_ready), 64'd1);
    sk_in_data = 32'h0000_000B;
    tick();
    // A still at the head, B captured into the skid slot, ready now low.
    chk_sk("bp_b", 1'b1, 32'h0000_000A, 2'd2);
    check("bp_b.ready", 64'(sk_in_ready), 64'd0);
    sk_in_data   = 32'h0000_00EE;   // held valid but must not be taken
    sk_out_ready = 1'b1;
    tick();
    sk_in_valid = 1'b0;
    chk_sk("bp_pop_a", 1'b1, 32'h0000_000B, 2'd1);
    check("bp_pop_a.ready", 64'(sk_in_ready), 64'd1);
    tick();
    chk_sk("bp_pop_b", 1'b0, BUB, 2'd0);
    check("bp.stall", 64'(sk_stall), 64'd1);

    // ---------------- SKID=1 flush of a full buffer with C incoming ----------------
    sk_out_ready = 1'b0;
    sk_in_valid  = 1'b1;
    sk_in_data   = 32'h0000_0011;
    tick();
    sk_in_data = 32'h0000_0022;
    tick();
    chk_sk("fl_full", 1'b1, 32'h0000_0011, 2'd2);
    sk_flush   = 1'b1;
    sk_in_data = 32'h0000_00CC;
    #1;
    check("fl_full.ready", 64'(sk_in_ready), 64'd0);
    tick();
    sk_flush     = 1'b0;
    sk_in_valid  = 1'b0;
    chk_sk("fl_after", 1'b0, BUB, 2'd0);
    sk_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_sk($sformatf("fl_quiet%0d", i), 1'b0, BUB, 2'd0);
    end
    // stall cycles: edge capturing 0x22 and the flush edge
    check("fl.stall", 64'(sk_stall), 64'd3);

    // flush with only M held: ready forced low even though S is empty
    sk_out_ready = 1'b0;
    sk_in_valid  = 1'b1;
    sk_in_data   = 32'h0000_00E1;
    tick();
    chk_sk("fl1_held", 1'b1, 32'h0000_00E1, 2'd1);
    sk_flush   = 1'b1;
    sk_in_data = 32'h0000_00F1;
    #1;
    check("fl1.ready", 64'(sk_in_ready), 64'd0);
    tick();
    sk_flush    = 1'b0;
    sk_in_valid = 1'b0;
    chk_sk("fl1_after", 1'b0, BUB, 2'd0);
    check("fl1.stall", 64'(sk_stall), 64'd4);

    // ---------------- SKID=0 ----------------
    sg_out_ready = 1'b0;
    sg_in_valid  = 1'b1;
    sg_in_data   = 32'h0000_0051;
    #1;
    check("sg_empty.ready", 64'(sg_in_ready), 64'd1);
    tick();
    chk_sg("sg_load", 1'b1, 32'h0000_0051, 2'd1);
    sg_in_data = 32'h0000_0052;
    #1;
    check("sg_full.ready", 64'(sg_in_ready), 64'd0);
    tick();
    chk_sg("sg_hold", 1'b1, 32'h0000_0051, 2'd1);
    sg_out_ready = 1'b1;
    #1;
    check("sg_pp.ready", 64'(sg_in_ready), 64'd1);
    tick();
    chk_sg("sg_pushpop", 1'b1, 32'h0000_0052, 2'd1);
    sg_in_valid = 1'b0;
    tick();
    chk_sg("sg_drain", 1'b0, BUB, 2'd0);
    check("sg.stall", 64'(sg_stall), 64'd1);
    sg_out_ready = 1'b0;
    sg_in_valid  = 1'b1;
    sg_in_data   = 32'h0000_0053;
    tick();
    chk_sg("sg_fl_held", 1'b1, 32'h0000_0053, 2'd1);
    sg_flush   = 1'b1;
    sg_in_data = 32'h0000_0054;
    #1;
    check("sg_fl.ready", 64'(sg_in_ready), 64'd0);
    tick();
    sg_flush    = 1'b0;
    sg_in_valid = 1'b0;
    chk_sg("sg_fl_after", 1'b0, BUB, 2'd0);
    check("sg_fl.stall", 64'(sg_stall), 64'd2);

    // ---------------- stall counter from a fresh reset (SKID=1) ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("st_reset.stall", 64'(sk_stall), 64'd0);
    chk_sk("st_reset", 1'b0, BUB, 2'd0);
    sk_out_ready = 1'b0;
    sk_in_valid  = 1'b1;
    sk_in_data   = 32'h0000_0077;
    tick();
    sk_in_valid = 1'b0;
    check("st_load.stall", 64'(sk_stall), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("st_5.stall", 64'(sk_stall), 64'd5);
    chk_sk("st_5", 1'b1, 32'h0000_0077, 2'd1);
    sk_flush     = 1'b1;
    sk_out_ready = 1'b1;
    tick();
    sk_flush     = 1'b0;
    sk_out_ready = 1'b0;
    check("st_flush.stall", 64'(sk_stall), 64'd5);
    chk_sk("st_flush", 1'b0, BUB, 2'd0);
    tick();
    check("st_after.stall", 64'(sk_stall), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
